// File: rtl/dcache_mem_ctrl.sv
// DCACHE miss/writeback engine: serialises an optional dirty-victim writeback and a
// 256-bit refill into single-word bus beats. Optional build macro: DCACHE_MEM_CRIT_WORD_FIRST_EN.
module dcache_mem_ctrl #(
    parameter int WORDS   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [31:0]  req_addr,
    input  logic         wb_valid,
    input  logic [31:0]  wb_addr,
    input  logic [255:0] wb_block,
    output logic [255:0] block_read,
    output logic         block_read_valid,
    output logic [31:0]  mem_addr,
    output logic         mem_rd,
    output logic         mem_wr,
    output logic [31:0]  mem_wdata,
    input  logic [31:0]  mem_rdata,
    input  logic         mem_ack,
    output logic [31:0]  crit_word,
    output logic         crit_word_valid,
    output logic         busy,
    output logic         err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] LAST_BEAT = 3'(WORDS - 1);

    typedef enum logic [2:0] {IDLE, WB, RD, DONE, ERR} state_t;

    state_t         state;
    logic [31:0]    req_base;
    logic [31:0]    wb_base;
    logic [255:0]   wb_buf;
    logic [2:0]     beat;
    logic [2:0]     start_off;
    logic [TW-1:0]  tcnt;
    logic [2:0]     rd_idx;
    logic           unused_bits;

    // Line-offset bits only matter for the fetch start word, and only in one build.
    assign unused_bits = ^{req_addr[4:0], wb_addr[4:0]};

    function automatic logic [31:0] word_of(input logic [255:0] blk, input logic [2:0] i);
        return blk[255 - 32*int'(i) -: 32];
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [2:0] k);
        return base | {27'd0, k, 2'b00};
    endfunction

    // Fill-buffer word index of the current read beat; start_off is 0 in the sequential build.
    assign rd_idx = start_off + beat;

`ifndef DCACHE_MEM_CRIT_WORD_FIRST_EN
    assign crit_word       = 32'd0;
    assign crit_word_valid = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state            <= IDLE;
            req_base         <= 32'd0;
            wb_base          <= 32'd0;
            wb_buf           <= 256'd0;
            beat             <= 3'd0;
            start_off        <= 3'd0;
            tcnt             <= '0;
            req_ready        <= 1'b1;
            block_read       <= 256'd0;
            block_read_valid <= 1'b0;
            mem_addr         <= 32'd0;
            mem_rd           <= 1'b0;
            mem_wr           <= 1'b0;
            mem_wdata        <= 32'd0;
            busy             <= 1'b0;
            err              <= 1'b0;
`ifdef DCACHE_MEM_CRIT_WORD_FIRST_EN
            crit_word        <= 32'd0;
            crit_word_valid  <= 1'b0;
`endif
        end else begin
            block_read_valid <= 1'b0;
`ifdef DCACHE_MEM_CRIT_WORD_FIRST_EN
            crit_word_valid  <= 1'b0;
`endif
            case (state)
                // DONE also has req_ready high, so a back-to-back request is taken there too.
                IDLE, DONE: begin
                    if (req_valid && req_ready) begin
                        req_base  <= {req_addr[31:5], 5'd0};
                        wb_base   <= {wb_addr[31:5], 5'd0};
                        wb_buf    <= wb_block;
                        beat      <= 3'd0;
                        tcnt      <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
`ifdef DCACHE_MEM_CRIT_WORD_FIRST_EN
                        start_off <= req_addr[4:2];
`else
                        start_off <= 3'd0;
`endif
                        if (wb_valid) begin
                            state     <= WB;
                            mem_wr    <= 1'b1;
                            mem_addr  <= {wb_addr[31:5], 5'd0};
                            mem_wdata <= word_of(wb_block, 3'd0);
                        end else begin
                            state    <= RD;
                            mem_rd   <= 1'b1;
`ifdef DCACHE_MEM_CRIT_WORD_FIRST_EN
                            mem_addr <= {req_addr[31:5], req_addr[4:2], 2'b00};
`else
                            mem_addr <= {req_addr[31:5], 5'd0};
`endif
                        end
                    end else begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        tcnt <= '0;
                        if (beat == LAST_BEAT) begin
                            state     <= RD;
                            beat      <= 3'd0;
                            mem_wr    <= 1'b0;
                            mem_rd    <= 1'b1;
                            mem_wdata <= 32'd0;
                            mem_addr  <= beat_addr(req_base, start_off);
                        end else begin
                            beat      <= beat + 3'd1;
                            mem_addr  <= beat_addr(wb_base, beat + 3'd1);
                            mem_wdata <= word_of(wb_buf, beat + 3'd1);
                        end
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        state  <= ERR;
                        err    <= 1'b1;
                        mem_wr <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RD: begin
                    if (mem_ack) begin
                        tcnt <= '0;
                        block_read[255 - 32*int'(rd_idx) -: 32] <= mem_rdata;
`ifdef DCACHE_MEM_CRIT_WORD_FIRST_EN
                        if (beat == 3'd0) begin
                            crit_word       <= mem_rdata;
                            crit_word_valid <= 1'b1;
                        end
`endif
                        if (beat == LAST_BEAT) begin
                            state            <= DONE;
                            beat             <= 3'd0;
                            mem_rd           <= 1'b0;
                            mem_addr         <= 32'd0;
                            block_read_valid <= 1'b1;
                            req_ready        <= 1'b1;
                        end else begin
                            beat     <= beat + 3'd1;
                            mem_addr <= beat_addr(req_base, rd_idx + 3'd1);
                        end
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        state  <= ERR;
                        err    <= 1'b1;
                        mem_rd <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ERR: begin
                    state     <= IDLE;
                    tcnt      <= '0;
                    beat      <= 3'd0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Directed-vector bench for dcache_mem_ctrl with a wait-state-configurable bus responder.
module tb_dcache_mem_ctrl;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [31:0]  req_addr = 32'd0;
    logic         wb_valid = 1'b0;
    logic [31:0]  wb_addr = 32'd0;
    logic [255:0] wb_block = 256'd0;
    logic [255:0] block_read;
    logic         block_read_valid;
    logic [31:0]  mem_addr;
    logic         mem_rd;
    logic         mem_wr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata = 32'd0;
    logic         mem_ack = 1'b0;
    logic [31:0]  crit_word;
    logic         crit_word_valid;
    logic         busy;
    logic         err;

    dcache_mem_ctrl #(.WORDS(8), .TIMEOUT(255)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_block(wb_block),
        .block_read(block_read), .block_read_valid(block_read_valid),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .crit_word(crit_word), .crit_word_valid(crit_word_valid),
        .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    localparam logic [255:0] FILL_EXP =
        256'hA0000000_A0000001_A0000002_A0000003_A0000004_A0000005_A0000006_A0000007;
    localparam logic [255:0] WB_DATA =
        256'h000000D0_000000D1_000000D2_000000D3_000000D4_000000D5_000000D6_000000D7;

    int vec_cnt = 0;
    int miss_cnt = 0;

    // Responder configuration and observation
    int          wait_n = 0;
    logic        no_ack = 1'b0;
    logic        stray_ack = 1'b0;
    int          wcnt = 0;
    int          unstable = 0;
    int          both_hi = 0;
    int          beat_cnt = 0;
    logic [31:0] p_addr = 32'd0;
    logic [31:0] p_wdata = 32'd0;
    logic        p_rd = 1'b0;
    logic [31:0] log_addr [64];
    logic [31:0] log_data [64];
    logic        log_wr   [64];

    int          crit_cnt;
    int          crit_cyc;
    logic [31:0] crit_val;
    logic        rr1;
    logic        busy1;
    logic        rr_done;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return 32'hA000_0000 + {29'd0, a[4:2]};
    endfunction

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Bus memory: acks after wait_n wait cycles, logs each beat as its ack is raised.
    always @(negedge CLK) begin
        if (mem_ack) wcnt = 0;
        mem_ack = 1'b0;
        if (mem_rd && mem_wr) both_hi++;
        if (mem_rd || mem_wr) begin
            if (wcnt > 0 && (mem_addr !== p_addr || mem_wdata !== p_wdata || mem_rd !== p_rd))
                unstable++;
            p_addr  = mem_addr;
            p_wdata = mem_wdata;
            p_rd    = mem_rd;
            if (!no_ack && wcnt == wait_n) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_model(mem_addr);
                if (beat_cnt < 64) begin
                    log_addr[beat_cnt] = mem_addr;
                    log_data[beat_cnt] = mem_wdata;
                    log_wr[beat_cnt]   = mem_wr;
                end
                beat_cnt++;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt    = 0;
            mem_ack = stray_ack;
        end
    end

    task automatic start_req(input logic [31:0] ra, input logic wv, input logic [31:0] wa,
                             input logic [255:0] wb);
        beat_cnt = 0;
        unstable = 0;
        crit_cnt = 0;
        crit_cyc = -1;
        crit_val = 32'd0;
        @(negedge CLK);
        req_valid = 1'b1;
        req_addr  = ra;
        wb_valid  = wv;
        wb_addr   = wa;
        wb_block  = wb;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        wb_valid  = 1'b0;
    endtask

    task automatic run_txn(input logic [31:0] ra, input logic wv, input logic [31:0] wa,
                           input logic [255:0] wb, input int budget, output int done_cyc);
        start_req(ra, wv, wa, wb);
        done_cyc = -1;
        rr_done  = 1'b0;
        for (int n = 1; n <= budget; n++) begin
            @(negedge CLK);
            if (n == 1) begin
                rr1   = req_ready;
                busy1 = busy;
            end
            if (crit_word_valid) begin
                crit_cnt++;
                crit_cyc = n;
                crit_val = crit_word;
            end
            if (block_read_valid) begin
                done_cyc = n;
                rr_done  = req_ready;
                break;
            end
        end
    endtask

    int dc;
    int pend;
    int err_cyc;
    int bv_seen;

    initial begin
        // Reset state
        repeat (3) @(negedge CLK);
        check_val("rst_req_ready", req_ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_err", err, 0);
        check_val("rst_mem_rd", mem_rd, 0);
        check_val("rst_mem_wr", mem_wr, 0);
        check_val("rst_brv", block_read_valid, 0);
        check_val("rst_block", block_read, 0);
        RESET = 1'b1;
        @(negedge CLK);

        // Stray ack while idle must be ignored
        stray_ack = 1'b1;
        repeat (3) @(negedge CLK);
        check_val("stray_busy", busy, 0);
        check_val("stray_rd", mem_rd, 0);
        check_val("stray_ready", req_ready, 1);
        stray_ack = 1'b0;
        @(negedge CLK);

        // Fill only, zero-wait
        wait_n = 0;
        run_txn(32'h0000_1044, 1'b0, 32'd0, 256'd0, 40, dc);
        check_val("f_done_cyc", dc, 9);
        check_val("f_ready_drop", rr1, 0);
        check_val("f_busy1", busy1, 1);
        check_val("f_ready_done", rr_done, 1);
        check_val("f_beats", beat_cnt, 8);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("f_addr%0d", i), log_addr[i], 32'h1040 + 4*i);
            check_val($sformatf("f_isrd%0d", i), log_wr[i], 0);
        end
        check_val("f_word0", block_read[255:224], 32'hA000_0000);
        check_val("f_word7", block_read[31:0], 32'hA000_0007);
        check_val("f_block", block_read, FILL_EXP);
        @(negedge CLK);
        check_val("f_pulse_width", block_read_valid, 0);

        // Writeback + fill, zero-wait
        run_txn(32'h0000_3008, 1'b1, 32'h0000_2010, WB_DATA, 60, dc);
        check_val("wb_done_cyc", dc, 17);
        check_val("wb_beats", beat_cnt, 16);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("wb_wr%0d", i), log_wr[i], 1);
            check_val($sformatf("wb_addr%0d", i), log_addr[i], 32'h2000 + 4*i);
            check_val($sformatf("wb_data%0d", i), log_data[i], 32'hD0 + i);
            check_val($sformatf("wb_raddr%0d", i), log_addr[8+i], 32'h3000 + 4*i);
            check_val($sformatf("wb_isrd%0d", i), log_wr[8+i], 0);
        end
        check_val("wb_block", block_read, FILL_EXP);

        // Three wait cycles per beat
        wait_n = 3;
        run_txn(32'h0000_1044, 1'b1, 32'h0000_2000, WB_DATA, 200, dc);
        check_val("ws_done_cyc", dc, 65);
        check_val("ws_beats", beat_cnt, 16);
        check_val("ws_stable", unstable, 0);
        check_val("ws_data3", log_data[3], 32'hD3);
        check_val("ws_addr12", log_addr[12], 32'h1050);
        check_val("ws_block", block_read, FILL_EXP);
        wait_n = 0;

        // Beat never acked
        no_ack = 1'b1;
        start_req(32'h0000_1044, 1'b0, 32'd0, 256'd0);
        pend = 0;
        err_cyc = -1;
        bv_seen = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge CLK);
            if (block_read_valid) bv_seen++;
            if (mem_rd) pend++;
            if (err) begin
                err_cyc = n;
                break;
            end
        end
        check_val("to_pending", pend, 255);
        check_val("to_err_cyc", err_cyc, 256);
        check_val("to_rd_low", mem_rd, 0);
        check_val("to_no_brv", bv_seen + block_read_valid, 0);
        check_val("to_err_ready", req_ready, 0);
        @(negedge CLK);
        check_val("to_ready_next", req_ready, 1);
        check_val("to_err_sticky", err, 1);
        check_val("to_busy_next", busy, 0);
        no_ack = 1'b0;
        @(negedge CLK);

        // Reset during beat 4 of a fill
        start_req(32'h0000_1044, 1'b0, 32'd0, 256'd0);
        repeat (4) @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check_val("mr_rd", mem_rd, 0);
        check_val("mr_wr", mem_wr, 0);
        check_val("mr_ready", req_ready, 1);
        check_val("mr_busy", busy, 0);
        check_val("mr_err", err, 0);
        check_val("mr_addr", mem_addr, 0);
        check_val("mr_block", block_read, 0);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        run_txn(32'h0000_1044, 1'b0, 32'd0, 256'd0, 40, dc);
        check_val("mr_done_cyc", dc, 9);
        check_val("mr_beats", beat_cnt, 8);
        check_val("mr_fill", block_read, FILL_EXP);

        // Unaligned miss address: fetch order depends on the build
        run_txn(32'h0000_101C, 1'b0, 32'd0, 256'd0, 40, dc);
        check_val("cw_done_cyc", dc, 9);
        check_val("cw_block", block_read, FILL_EXP);
`ifdef DCACHE_MEM_CRIT_WORD_FIRST_EN
        check_val("cw_first_addr", log_addr[0], 32'h101C);
        check_val("cw_second_addr", log_addr[1], 32'h1000);
        check_val("cw_last_addr", log_addr[7], 32'h1018);
        check_val("cw_cnt", crit_cnt, 1);
        check_val("cw_cyc", crit_cyc, 2);
        check_val("cw_val", crit_val, 32'hA000_0007);
`else
        check_val("cw_first_addr", log_addr[0], 32'h1000);
        check_val("cw_last_addr", log_addr[7], 32'h101C);
        check_val("cw_cnt", crit_cnt, 0);
        check_val("cw_tied", crit_word, 0);
`endif
        check_val("rd_wr_excl", both_hi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
